uart_rx_frame: RTL and testbench

//  Receive side of the SoC UART: deserializes io_uart_rx frames (1 start, 8 data LSB-first, even parity, 1 stop).

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_fifo.sv | 55 +++++
 rtl/uart_rx_frame.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the UART receive path: FSM state encoding and the byte record
// that travels from the deserializer to the consumer together with its error flags.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

  typedef struct packed {
    logic                      ferr;
    logic                      perr;
    logic [UART_DATA_BITS-1:0] data;
  } rx_byte_t;

  localparam int RX_BYTE_W = $bits(rx_byte_t);

endpackage

// File: rtl/uart_rx_fifo.sv
// Small output queue of received bytes; only used when UART_RX_FIFO_EN is defined.
// A push into a full queue is accepted when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [RX_BYTE_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RX_BYTE_W-1:0] out_data
);

  localparam int AW = $clog2(DEPTH);

  rx_byte_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          do_push;
  logic          do_pop;

  // Extra wrap bit distinguishes full from empty when the index bits match.
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign out_valid = ~empty;
  assign in_ready  = ~full | out_ready;
  assign do_push   = in_valid & in_ready;
  assign do_pop    = out_valid & out_ready;
  assign out_data  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= rx_byte_t'(in_data);
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receiver: 8E1 frames oversampled by a runtime divisor, bytes out on valid/ready.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry output queue; otherwise one holding register.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_perr,
  output logic             out_ferr,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end

  logic                      rx_meta;
  logic                      rx_s;
  logic                      rx_prev;
  rx_state_e                 state;
  rx_state_e                 state_next;
  logic [DIV_W-1:0]          cnt;
  logic [DIV_W-1:0]          cnt_next;
  logic [DIV_W-1:0]          div_lat;
  logic [DIV_W-1:0]          div_next;
  logic [2:0]                bit_idx;
  logic [2:0]                bit_next;
  logic [UART_DATA_BITS-1:0] shift;
  logic [UART_DATA_BITS-1:0] shift_next;
  logic                      perr_q;
  logic                      perr_next;
  logic                      tick;
  logic                      push;
  rx_byte_t                  push_byte;
  logic                      push_ready;
  rx_byte_t                  head;

  // The line idles high, so the synchronizer resets to 1 to avoid a fake start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      div_lat <= '0;
      bit_idx <= '0;
      shift   <= '0;
      perr_q  <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      div_lat <= div_next;
      bit_idx <= bit_next;
      shift   <= shift_next;
      perr_q  <= perr_next;
    end
  end

  assign tick = (cnt == '0);

  // Every sampling state counts down to zero and samples there; only the sample action differs.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    div_next   = div_lat;
    bit_next   = bit_idx;
    shift_next = shift;
    perr_next  = perr_q;
    push       = 1'b0;
    push_byte  = '0;
    if (state != IDLE && state != BREAK && !tick) begin
      cnt_next = cnt - DIV_W'(1);
    end
    case (state)
      IDLE: begin
        if (rx_prev && !rx_s) begin
          div_next   = divisor;
          cnt_next   = divisor >> 1;
          state_next = START;
        end
      end
      START: begin
        if (tick) begin
          if (rx_s) begin
            state_next = IDLE;
          end else begin
            cnt_next   = div_lat - DIV_W'(1);
            bit_next   = '0;
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_next = {rx_s, shift[UART_DATA_BITS-1:1]};
          cnt_next   = div_lat - DIV_W'(1);
          if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
            state_next = PARITY;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          perr_next  = rx_s ^ (^shift);
          cnt_next   = div_lat - DIV_W'(1);
          state_next = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          push           = 1'b1;
          push_byte.ferr = ~rx_s;
          push_byte.perr = perr_q;
          push_byte.data = shift;
          state_next     = rx_s ? IDLE : BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef UART_RX_FIFO_EN
  logic [RX_BYTE_W-1:0] fifo_head;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (push),
    .in_ready  (push_ready),
    .in_data   (push_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (fifo_head)
  );

  assign head = rx_byte_t'(fifo_head);
`else
  rx_byte_t hold;
  logic     hold_valid;

  assign push_ready = ~hold_valid | out_ready;

  // A new byte may replace the held one in the cycle it is being consumed.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold       <= '0;
      hold_valid <= 1'b0;
    end else if (push && push_ready) begin
      hold       <= push_byte;
      hold_valid <= 1'b1;
    end else if (hold_valid && out_ready) begin
      hold_valid <= 1'b0;
    end
  end

  assign out_valid = hold_valid;
  assign head      = hold;
`endif

  // Set has priority so a drop coinciding with a clear is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (push && !push_ready) begin
      overrun <= 1'b1;
    end else if (overrun_clr) begin
      overrun <= 1'b0;
    end
  end

  assign out_data = head.data;
  assign out_perr = head.perr;
  assign out_ferr = head.ferr;
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed self-checking bench for uart_rx_frame at divisor 6, plus back-to-back frames
// at divisor 4 and 1000; expectations follow UART_RX_FIFO_EN when it is defined.
module tb_uart_rx_frame;

  localparam int DIV_W      = 16;
  localparam int FIFO_DEPTH = 8;
`ifdef UART_RX_FIFO_EN
  localparam int HOLD = FIFO_DEPTH;
`else
  localparam int HOLD = 1;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             rx;
  logic [DIV_W-1:0] divisor;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic             out_perr;
  logic             out_ferr;
  logic             overrun;
  logic             overrun_clr;
  logic             busy;

  int         total = 0;
  int         bad   = 0;
  logic [9:0] seen[$];

  always #5 clk = ~clk;

  uart_rx_frame #(
    .DIV_W      (DIV_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .rx          (rx),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_perr    (out_perr),
    .out_ferr    (out_ferr),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .busy        (busy)
  );

  // Record every completed transfer as {ferr, perr, data}.
  always @(negedge clk) begin
    #1;
    if (!reset && out_valid && out_ready) begin
      seen.push_back({out_ferr, out_perr, out_data});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic par_flip,
                               input logic stop_bit, input int div);
    rx = 1'b0;
    repeat (div) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (div) @(negedge clk);
    end
    rx = (^d) ^ par_flip;
    repeat (div) @(negedge clk);
    rx = stop_bit;
    repeat (div) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkByte(input string tag, input logic [9:0] exp);
    logic [9:0] got;
    got = 'x;
    if (seen.size() > 0) got = seen.pop_front();
    checkOutput(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    reset       = 1'b1;
    rx          = 1'b1;
    out_ready   = 1'b1;
    overrun_clr = 1'b0;
    divisor     = 16'd6;
    repeat (3) @(negedge clk);

    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_perr", 32'(out_perr), 32'd0);
    checkOutput("rst_ferr", 32'(out_ferr), 32'd0);
    checkOutput("rst_overrun", 32'(overrun), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(5);

    $display("[TB] clean byte 0xA5");
    seen.delete();
    applyStimulus(8'hA5, 1'b0, 1'b1, 6);
    idle(10);
    checkOutput("t1_count", 32'(seen.size()), 32'd1);
    checkByte("t1_byte", 10'h0A5);
    checkOutput("t1_overrun", 32'(overrun), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);

    $display("[TB] parity error on 0x37");
    applyStimulus(8'h37, 1'b1, 1'b1, 6);
    idle(10);
    checkOutput("t2_count", 32'(seen.size()), 32'd1);
    checkByte("t2_byte", 10'h137);

    $display("[TB] framing error then break");
    applyStimulus(8'h00, 1'b0, 1'b0, 6);
    idle(30);
    checkOutput("t3_count_break", 32'(seen.size()), 32'd1);
    checkOutput("t3_busy_break", 32'(busy), 32'd1);
    rx = 1'b1;
    idle(10);
    checkOutput("t3_count_released", 32'(seen.size()), 32'd1);
    checkOutput("t3_busy_released", 32'(busy), 32'd0);
    applyStimulus(8'h5A, 1'b0, 1'b1, 6);
    idle(10);
    checkByte("t3_break_byte", 10'h200);
    checkByte("t3_after_byte", 10'h05A);
    checkOutput("t3_count_end", 32'(seen.size()), 32'd0);

    $display("[TB] glitch on idle line");
    rx = 1'b0;
    idle(2);
    rx = 1'b1;
    idle(1);
    checkOutput("t4_busy_start", 32'(busy), 32'd1);
    idle(5);
    checkOutput("t4_busy_end", 32'(busy), 32'd0);
    checkOutput("t4_count", 32'(seen.size()), 32'd0);

    $display("[TB] backpressure and overrun, hold=%0d", HOLD);
    out_ready = 1'b0;
    for (int i = 0; i < HOLD; i++) begin
      applyStimulus(8'(8'h10 + i), 1'b0, 1'b1, 6);
    end
    idle(5);
    checkOutput("t5_overrun_at_full", 32'(overrun), 32'd0);
    checkOutput("t5_valid_held", 32'(out_valid), 32'd1);
    applyStimulus(8'(8'h10 + HOLD), 1'b0, 1'b1, 6);
    idle(5);
    checkOutput("t5_overrun_set", 32'(overrun), 32'd1);
    checkOutput("t5_head_data", 32'(out_data), 32'h10);
    overrun_clr = 1'b1;
    idle(1);
    overrun_clr = 1'b0;
    checkOutput("t5_overrun_clr", 32'(overrun), 32'd0);
    out_ready = 1'b1;
    idle(HOLD + 3);
    checkOutput("t5_count", 32'(seen.size()), 32'(HOLD));
    for (int i = 0; i < HOLD; i++) begin
      checkByte($sformatf("t5_byte%0d", i), {2'b00, 8'(8'h10 + i)});
    end
    checkOutput("t5_drained", 32'(out_valid), 32'd0);

    $display("[TB] reset mid-frame");
    out_ready = 1'b0;
    applyStimulus(8'h11, 1'b0, 1'b1, 6);
    idle(5);
    checkOutput("t6_valid_before", 32'(out_valid), 32'd1);
    rx = 1'b0;
    idle(6);
    rx = 1'b1;
    idle(12);
    checkOutput("t6_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    idle(1);
    checkOutput("t6_valid_reset", 32'(out_valid), 32'd0);
    checkOutput("t6_busy_reset", 32'(busy), 32'd0);
    checkOutput("t6_data_reset", 32'(out_data), 32'd0);
    reset     = 1'b0;
    out_ready = 1'b1;
    seen.delete();
    idle(10);
    applyStimulus(8'hC3, 1'b0, 1'b1, 6);
    idle(10);
    checkOutput("t6_count", 32'(seen.size()), 32'd1);
    checkByte("t6_byte", 10'h0C3);

    $display("[TB] back-to-back at divisor 4");
    divisor = 16'd4;
    applyStimulus(8'h81, 1'b0, 1'b1, 4);
    applyStimulus(8'h7E, 1'b0, 1'b1, 4);
    applyStimulus(8'h01, 1'b0, 1'b1, 4);
    idle(10);
    checkOutput("t7_count", 32'(seen.size()), 32'd3);
    checkByte("t7_byte0", 10'h081);
    checkByte("t7_byte1", 10'h07E);
    checkByte("t7_byte2", 10'h001);

    $display("[TB] back-to-back at divisor 1000");
    divisor = 16'd1000;
    applyStimulus(8'hE7, 1'b0, 1'b1, 1000);
    applyStimulus(8'h3C, 1'b1, 1'b1, 1000);
    idle(20);
    checkOutput("t8_count", 32'(seen.size()), 32'd2);
    checkByte("t8_byte0", 10'h0E7);
    checkByte("t8_byte1", 10'h13C);
    checkOutput("t8_overrun", 32'(overrun), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
